// File: rtl/phase_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cycle_ctrl
//  Purpose  : Multi-phase processor cycle sequencer with run, single-step and
//             cycle-count breakpoint control driven from asynchronous inputs.
//  Revision : 1.0
// ============================================================================
module phase_cycle_ctrl #(
  parameter int PHASES      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clkX4,
  input  logic              rst,
  input  logic              sigCH,
  input  logic              sigCE,
  input  logic              sigCP,
  input  logic [CNT_W-1:0]  brkCycle,
  output logic [PHASES-1:0] phase,
  output logic              cpuClkEn,
  output logic [CNT_W-1:0]  cycle,
  output logic              running,
  output logic              brkHit
);

  localparam int              PH_W         = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] c_LAST_PHASE = PH_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [SYNC_STAGES-1:0] r_chSync;
  logic [SYNC_STAGES-1:0] r_ceSync;
  logic [SYNC_STAGES-1:0] r_cpSync;
  logic [SYNC_STAGES-1:0] r_syncFill;
  logic                   r_cpPrev;
  logic                   r_cpArmed;
  logic [PH_W-1:0]        r_phaseCnt;
  logic [CNT_W-1:0]       r_cycle;

  logic                   w_chSync;
  logic                   w_ceSync;
  logic                   w_cpSync;
  logic                   w_syncValid;
  logic                   w_stepReq;
  logic                   w_running;
  logic                   w_cpuClkEn;
  logic [CNT_W-1:0]       w_cycleNext;
  logic                   w_brkMatch;

  // Input synchronizers; r_syncFill marks when the chains hold real samples
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_chSync   <= '0;
      r_ceSync   <= '0;
      r_cpSync   <= '0;
      r_syncFill <= '0;
      r_cpPrev   <= 1'b0;
      r_cpArmed  <= 1'b0;
    end else begin
      r_chSync   <= {r_chSync[SYNC_STAGES-2:0], sigCH};
      r_ceSync   <= {r_ceSync[SYNC_STAGES-2:0], sigCE};
      r_cpSync   <= {r_cpSync[SYNC_STAGES-2:0], sigCP};
      r_syncFill <= {r_syncFill[SYNC_STAGES-2:0], 1'b1};
      r_cpPrev   <= w_cpSync;
      r_cpArmed  <= r_cpArmed | (w_syncValid & ~w_cpSync);
    end
  end

  assign w_chSync    = r_chSync[SYNC_STAGES-1];
  assign w_ceSync    = r_ceSync[SYNC_STAGES-1];
  assign w_cpSync    = r_cpSync[SYNC_STAGES-1];
  assign w_syncValid = r_syncFill[SYNC_STAGES-1];

  // A button held through reset release must be seen low before it can step
  assign w_stepReq   = w_cpSync & ~r_cpPrev & r_cpArmed;

  assign w_running   = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_cpuClkEn  = w_running && (r_phaseCnt == c_LAST_PHASE);
  assign w_cycleNext = r_cycle + c_CNT_ONE;
  assign w_brkMatch  = w_ceSync && (w_cycleNext == brkCycle);

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_chSync) begin
          w_nextState = S_RUN;
        end else if (w_stepReq) begin
          w_nextState = S_STEP;
        end
      end
      S_RUN: begin
        if (w_cpuClkEn) begin
          if (w_brkMatch) begin
            w_nextState = S_BREAK;
          end else if (!w_chSync) begin
            w_nextState = S_IDLE;
          end
        end
      end
      S_STEP: begin
        if (w_cpuClkEn) begin
          w_nextState = S_IDLE;
        end
      end
      S_BREAK: begin
        if (!w_chSync) begin
          w_nextState = S_IDLE;
        end else if (w_stepReq) begin
          w_nextState = S_STEP;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_phaseCnt <= '0;
      r_cycle    <= '0;
    end else begin
      if (!w_running || (r_phaseCnt == c_LAST_PHASE)) begin
        r_phaseCnt <= '0;
      end else begin
        r_phaseCnt <= r_phaseCnt + PH_W'(1);
      end
      if (w_cpuClkEn) begin
        r_cycle <= w_cycleNext;
      end
    end
  end

  generate
    for (genvar k = 0; k < PHASES; k++) begin : g_phase
      assign phase[k] = (r_phaseCnt == PH_W'(k));
    end
  endgenerate

  assign cpuClkEn = w_cpuClkEn;
  assign cycle    = r_cycle;
  assign running  = w_running;
  assign brkHit   = (r_state == S_BREAK);

endmodule
`default_nettype wire

// File: tb/tb_phase_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_cycle_ctrl
//  Purpose  : Scoreboard bench for phase_cycle_ctrl (default and CNT_W=4).
//  Revision : 1.0
// ============================================================================
module tb_phase_cycle_ctrl;

  logic        clk;
  logic        rst;
  logic        ch, ce, cp;
  logic [31:0] brk;
  logic [3:0]  phase;
  logic        en;
  logic [31:0] cyc;
  logic        run;
  logic        hit;

  logic        ch4, ce4, cp4;
  logic [3:0]  brk4;
  logic [3:0]  phase4;
  logic        en4;
  logic [3:0]  cyc4;
  logic        run4;
  logic        hit4;

  int          checks;
  int          errors;
  logic [31:0] q[$];
  logic [3:0]  q4[$];
  bit          prevEn;
  bit          prevEn4;

  phase_cycle_ctrl dut (
    .clkX4(clk), .rst(rst), .sigCH(ch), .sigCE(ce), .sigCP(cp),
    .brkCycle(brk), .phase(phase), .cpuClkEn(en), .cycle(cyc),
    .running(run), .brkHit(hit)
  );

  phase_cycle_ctrl #(.PHASES(4), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clkX4(clk), .rst(rst), .sigCH(ch4), .sigCE(ce4), .sigCP(cp4),
    .brkCycle(brk4), .phase(phase4), .cpuClkEn(en4), .cycle(cyc4),
    .running(run4), .brkHit(hit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and retire any cpuClkEn seen last clock
  task automatic tick();
    logic [31:0] e;
    logic [3:0]  e4;
    @(negedge clk);
    if (prevEn) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL cpuClkEn_unexpected: cycle=%0d, required no pulse", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL cycle_count: got %0d, expected %0d", cyc, e);
        end
      end
    end
    if (prevEn4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL cpuClkEn4_unexpected: cycle=%0d, required no pulse", cyc4);
      end else begin
        e4 = q4.pop_front();
        if (cyc4 !== e4) begin
          errors++;
          $display("FAIL cycle4_count: got %0d, expected %0d", cyc4, e4);
        end
      end
    end
    prevEn  = (en === 1'b1);
    prevEn4 = (en4 === 1'b1);
  endtask

  task automatic expect1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ch = 0; ce = 0; cp = 0; brk = '0;
    ch4 = 0; ce4 = 0; cp4 = 0; brk4 = '0;
    repeat (3) tick();
    expect1("reset_phase", 32'(phase), 32'h1);
    expect1("reset_en", 32'(en), 32'h0);
    expect1("reset_cycle", cyc, 32'h0);
    expect1("reset_running", 32'(run), 32'h0);
    expect1("reset_brkHit", 32'(hit), 32'h0);
    expect1("reset_phase4", 32'(phase4), 32'h1);
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_run();
    logic [3:0] expPh;
    for (int i = 1; i <= 100; i++) q.push_back(32'(i));
    ch = 1'b1;
    tick(); tick();
    expect1("run_latency_early", 32'(run), 32'h0);
    tick();
    expect1("run_entry", 32'(run), 32'h1);
    expect1("run_entry_phase", 32'(phase), 32'h1);
    for (int k = 1; k <= 400; k++) begin
      tick();
      expPh = 4'b0001 << (k % 4);
      expect1("run_phase", 32'(phase), 32'(expPh));
      expect1("run_en", 32'(en), 32'((k % 4) == 3));
    end
    expect1("run_cycle100", cyc, 32'd100);
    expect1("run_queue", 32'(q.size()), 32'h0);
  endtask

  task automatic test_drop();
    tick();
    expect1("drop_phase1", 32'(phase), 32'h2);
    q.push_back(32'd101);
    ch = 1'b0;
    repeat (8) tick();
    expect1("drop_running", 32'(run), 32'h0);
    expect1("drop_phase", 32'(phase), 32'h1);
    expect1("drop_cycle", cyc, 32'd101);
    repeat (8) tick();
    expect1("drop_stable", cyc, 32'd101);
    expect1("drop_queue", 32'(q.size()), 32'h0);
  endtask

  task automatic test_step();
    q.push_back(32'd102);
    cp = 1'b1;
    tick(); tick();
    cp = 1'b0;
    tick();
    expect1("step_entry", 32'(run), 32'h1);
    cp = 1'b1;
    repeat (3) tick();
    cp = 1'b0;
    repeat (12) tick();
    for (int p = 0; p < 2; p++) begin
      q.push_back(32'(103 + p));
      cp = 1'b1;
      repeat (4) tick();
      cp = 1'b0;
      repeat (12) tick();
    end
    expect1("step_cycle", cyc, 32'd104);
    expect1("step_running", 32'(run), 32'h0);
    expect1("step_queue", 32'(q.size()), 32'h0);
  endtask

  task automatic test_reset_cp_held();
    cp = 1'b1;
    rst = 1'b0;
    tick();
    expect1("rst_cycle_clear", cyc, 32'h0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    expect1("cp_held_no_step", 32'(run), 32'h0);
    cp = 1'b0;
    repeat (6) tick();
    expect1("cp_release_no_step", 32'(run), 32'h0);
    expect1("cp_held_cycle", cyc, 32'h0);
  endtask

  task automatic test_break();
    int n;
    brk = 32'd10; ce = 1'b1;
    for (int i = 1; i <= 10; i++) q.push_back(32'(i));
    ch = 1'b1;
    n = 0;
    while (hit !== 1'b1 && n < 200) begin tick(); n++; end
    expect1("brk_reached", 32'(hit), 32'h1);
    expect1("brk_cycle", cyc, 32'd10);
    expect1("brk_queue", 32'(q.size()), 32'h0);
    repeat (8) tick();
    expect1("brk_phase_frozen", 32'(phase), 32'h1);
    expect1("brk_hold", 32'(hit), 32'h1);
    expect1("brk_running", 32'(run), 32'h0);
    expect1("brk_cycle_hold", cyc, 32'd10);
    q.push_back(32'd11);
    cp = 1'b1;
    n = 0;
    while (run !== 1'b1 && n < 10) begin tick(); n++; end
    expect1("brk_step_entry", 32'(run), 32'h1);
    ch = 1'b0; cp = 1'b0;
    repeat (10) tick();
    expect1("brk_step_idle", 32'(run), 32'h0);
    expect1("brk_step_clear", 32'(hit), 32'h0);
    expect1("brk_step_cycle", cyc, 32'd11);
    for (int i = 12; i <= 15; i++) q.push_back(32'(i));
    ch = 1'b1;
    wait_empty(100);
    q.push_back(32'd16);
    ch = 1'b0;
    repeat (10) tick();
    expect1("resume_cycle", cyc, 32'd16);
    expect1("resume_idle", 32'(run), 32'h0);
    expect1("resume_nohit", 32'(hit), 32'h0);
    expect1("resume_queue", 32'(q.size()), 32'h0);
    ce = 1'b0;
  endtask

  task automatic test_midcycle_reset();
    int n;
    ch = 1'b1;
    n = 0;
    while (phase !== 4'b0100 && n < 20) begin tick(); n++; end
    expect1("mid_phase2", 32'(phase), 32'h4);
    #1 rst = 1'b0;
    #1;
    expect1("mid_rst_phase", 32'(phase), 32'h1);
    expect1("mid_rst_en", 32'(en), 32'h0);
    expect1("mid_rst_cycle", cyc, 32'h0);
    expect1("mid_rst_running", 32'(run), 32'h0);
    expect1("mid_rst_brkHit", 32'(hit), 32'h0);
    ch = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (6) tick();
    expect1("mid_after_running", 32'(run), 32'h0);
    expect1("mid_after_cycle", cyc, 32'h0);
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 1; i <= 17; i++) q4.push_back(4'(i));
    ch4 = 1'b1;
    n = 0;
    while (q4.size() != 0 && n < 200) begin tick(); n++; end
    expect1("wrap_drain", 32'(q4.size()), 32'h0);
    expect1("wrap_cycle1", 32'(cyc4), 32'h1);
    q4.push_back(4'd2);
    ch4 = 1'b0;
    repeat (10) tick();
    expect1("wrap_cycle2", 32'(cyc4), 32'h2);
    expect1("wrap_idle", 32'(run4), 32'h0);
    brk4 = 4'd0; ce4 = 1'b1;
    for (int i = 3; i <= 16; i++) q4.push_back(4'(i));
    ch4 = 1'b1;
    n = 0;
    while (hit4 !== 1'b1 && n < 200) begin tick(); n++; end
    expect1("wrap_brk_hit", 32'(hit4), 32'h1);
    expect1("wrap_brk_cycle", 32'(cyc4), 32'h0);
    expect1("wrap_brk_queue", 32'(q4.size()), 32'h0);
    ch4 = 1'b0;
    repeat (6) tick();
    expect1("wrap_brk_exit", 32'(hit4), 32'h0);
    expect1("wrap_brk_idle", 32'(run4), 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0;
    prevEn = 0; prevEn4 = 0;
    test_reset();
    test_run();
    test_drop();
    test_step();
    test_reset_cp_held();
    test_break();
    test_midcycle_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
